// File: rtl/col_output_packer_if.sv
// Lane-result ingress and packed-word egress bundle for col_output_packer.
interface col_output_packer_if #(
   parameter int LANES = 8,
   parameter int DW    = 8,
   parameter int OW    = 32,
   parameter int DEPTH = 4
);
   logic [DW-1:0]          in_r [LANES];
   logic [LANES-1:0]       in_v;
   logic                   rread;
   logic                   clr_err;
   logic [OW-1:0]          out_r;
   logic                   rvalid;
   logic [$clog2(DEPTH):0] level;
   logic                   ovf;
   logic                   coll;

   modport master (
      output in_r, in_v, rread, clr_err,
      input  out_r, rvalid, level, ovf, coll
   );

   modport slave (
      input  in_r, in_v, rread, clr_err,
      output out_r, rvalid, level, ovf, coll
   );
endinterface

// File: rtl/col_output_packer.sv
// Gathers skewed per-lane column results into rows, queues them, emits OW-bit beats.
// Row visible one cycle after completion; full FIFO drops rows (ovf) unless the head pops that cycle.
module col_output_packer #(
   parameter int LANES = 8,
   parameter int DW    = 8,
   parameter int OW    = 32,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rstn,
   col_output_packer_if.slave bus
);
   localparam int ROWW  = LANES * DW;
   localparam int BEATS = ROWW / OW;
   localparam int AW    = $clog2(DEPTH);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (((ROWW % OW) != 0) || ((OW % DW) != 0)) begin : g_bad_width
      $error("col_output_packer: LANES*DW must be a multiple of OW and OW a multiple of DW");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("col_output_packer: DEPTH must be a power of 2 and at least 2");
   end

   logic [DW-1:0]    stage_q [LANES];
   logic [DW-1:0]    stage_d [LANES];
   logic [LANES-1:0] cap_q, cap_d;
   logic [ROWW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             ovf_q, ovf_d;
   logic             coll_q, coll_d;

   logic             row_done, full, rd_fire, last_beat;
   logic             pop, push, drop, coll_set;
   logic [ROWW-1:0]  row_d, head_row;
   logic [OW-1:0]    out_word;

   always_comb begin
      row_done  = &(cap_q | bus.in_v);
      full      = (level_q == (AW+1)'(DEPTH));
      rd_fire   = bus.rread & (level_q != '0);
      last_beat = (beat_q == BW'(BEATS - 1));
      pop       = rd_fire & last_beat;
      // A final-beat pop frees the slot in the same edge, so a full FIFO can still accept.
      push      = row_done & (~full | pop);
      drop      = row_done & full & ~pop;
      coll_set  = (|(bus.in_v & cap_q)) & ~row_done;
   end

   always_comb begin
      stage_d = stage_q;
      row_d   = '0;
      for (int k = 0; k < LANES; k++) begin
         stage_d[k]          = bus.in_v[k] ? bus.in_r[k] : stage_q[k];
         row_d[k*DW +: DW]   = stage_d[k];
      end
   end

   always_comb begin
      cap_d    = row_done ? '0 : (cap_q | bus.in_v);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
      beat_d   = beat_q;
      if (rd_fire) begin
         beat_d = last_beat ? '0 : beat_q + BW'(1);
      end
      ovf_d    = drop | (ovf_q & ~bus.clr_err);
      coll_d   = coll_set | (coll_q & ~bus.clr_err);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < LANES; k++) begin
            stage_q[k] <= '0;
         end
         cap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         beat_q   <= '0;
         ovf_q    <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         cap_q    <= cap_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         coll_q   <= coll_d;
      end
   end

   // Row storage needs no reset: level gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= row_d;
      end
   end

   always_comb begin
      head_row = mem_q[rd_ptr_q];
      out_word = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_q == BW'(b)) begin
            out_word = head_row[b*OW +: OW];
         end
      end
   end

   assign bus.rvalid = (level_q != '0);
   assign bus.out_r  = (level_q != '0) ? out_word : '0;
   assign bus.level  = level_q;
   assign bus.ovf    = ovf_q;
   assign bus.coll   = coll_q;
endmodule

// File: tb/tb_col_output_packer.sv
// Scenario bench for col_output_packer: expected beats queued at row completion, compared on readout.
module tb_col_output_packer;
   localparam int LANES = 8;
   localparam int DW    = 8;
   localparam int OW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   passed = 0;
   logic [OW-1:0] exp_q [$];

   col_output_packer_if #(.LANES(LANES), .DW(DW), .OW(OW), .DEPTH(DEPTH)) bus ();

   col_output_packer #(.LANES(LANES), .DW(DW), .OW(OW), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_v    = '0;
      bus.rread   = 1'b0;
      bus.clr_err = 1'b0;
      for (int k = 0; k < LANES; k++) bus.in_r[k] = '0;
   endtask

   task automatic drive_row(input logic [LANES*DW-1:0] row, input logic [LANES-1:0] mask);
      for (int k = 0; k < LANES; k++) bus.in_r[k] = row[k*DW +: DW];
      bus.in_v = mask;
   endtask

   task automatic expect_row(input logic [LANES*DW-1:0] row);
      for (int b = 0; b < (LANES*DW)/OW; b++) exp_q.push_back(row[b*OW +: OW]);
   endtask

   task automatic drain(input string nm);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         logic [OW-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (bus.rvalid !== 1'b1 || bus.out_r !== e)
            $display("FAIL %s beat %0d: rvalid=%b out_r=%h, required rvalid=1 out_r=%h",
                     nm, i, bus.rvalid, bus.out_r, e);
         else passed++;
         bus.rread = 1'b1;
         tick();
         bus.rread = 1'b0;
      end
      checks++;
      if (bus.rvalid !== 1'b0 || bus.level !== 3'd0 || bus.out_r !== 32'h0)
         $display("FAIL %s empty: rvalid=%b level=%0d out_r=%h, required 0 0 0",
                  nm, bus.rvalid, bus.level, bus.out_r);
      else passed++;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      #2;
      checks++;
      if (bus.rvalid !== 1'b0 || bus.out_r !== 32'h0 || bus.level !== 3'd0 ||
          bus.ovf !== 1'b0 || bus.coll !== 1'b0)
         $display("FAIL reset: rvalid=%b out_r=%h level=%0d ovf=%b coll=%b, required all 0",
                  bus.rvalid, bus.out_r, bus.level, bus.ovf, bus.coll);
      else passed++;
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_full_row();
      drive_row(64'h0807060504030201, 8'hFF);
      expect_row(64'h0807060504030201);
      tick();
      idle_inputs();
      checks++;
      if (bus.rvalid !== 1'b1 || bus.level !== 3'd1)
         $display("FAIL full_row latency: rvalid=%b level=%0d, required 1 1", bus.rvalid, bus.level);
      else passed++;
      drain("full_row");
   endtask

   task automatic test_skewed();
      idle_inputs();
      for (int k = 0; k < LANES; k++) begin
         bus.in_v    = LANES'(1) << k;
         bus.in_r[k] = DW'(k + 1);
         if (k == LANES - 1) expect_row(64'h0807060504030201);
         tick();
         if (k < LANES - 1) begin
            checks++;
            if (bus.level !== 3'd0)
               $display("FAIL skew early push lane %0d: level=%0d, required 0", k, bus.level);
            else passed++;
         end
      end
      idle_inputs();
      checks++;
      if (bus.level !== 3'd1 || bus.coll !== 1'b0)
         $display("FAIL skew complete: level=%0d coll=%b, required 1 0", bus.level, bus.coll);
      else passed++;
      drain("skewed");
   endtask

   task automatic test_collision();
      idle_inputs();
      bus.in_v = 8'h04; bus.in_r[2] = 8'h11;
      tick();
      bus.in_r[2] = 8'h22;
      tick();
      idle_inputs();
      checks++;
      if (bus.coll !== 1'b1 || bus.level !== 3'd0)
         $display("FAIL coll set: coll=%b level=%0d, required 1 0", bus.coll, bus.level);
      else passed++;
      drive_row(64'hA7A6A5A4A3A2A1A0, 8'hFB);
      expect_row(64'hA7A6A5A4A322A1A0);
      tick();
      idle_inputs();
      drain("coll_row");
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.coll !== 1'b0) $display("FAIL coll clear: coll=%b, required 0", bus.coll);
      else passed++;
      // set and clear in the same cycle: set wins
      bus.in_v = 8'h04; bus.in_r[2] = 8'h33;
      tick();
      bus.in_r[2] = 8'h44; bus.clr_err = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (bus.coll !== 1'b1) $display("FAIL coll set-wins: coll=%b, required 1", bus.coll);
      else passed++;
      drive_row(64'hB7B6B5B4B3B2B1B0, 8'hFB);
      expect_row(64'hB7B6B5B4B344B1B0);
      tick();
      idle_inputs();
      drain("coll_row2");
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
   endtask

   task automatic test_overflow();
      logic [LANES*DW-1:0] row;
      idle_inputs();
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < LANES; k++) row[k*DW +: DW] = DW'(r*16 + k);
         drive_row(row, 8'hFF);
         if (r < DEPTH) expect_row(row);
         tick();
      end
      idle_inputs();
      checks++;
      if (bus.level !== 3'd4 || bus.ovf !== 1'b1)
         $display("FAIL overflow: level=%0d ovf=%b, required 4 1", bus.level, bus.ovf);
      else passed++;
      drain("overflow");
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      checks++;
      if (bus.ovf !== 1'b0) $display("FAIL ovf clear: ovf=%b, required 0", bus.ovf);
      else passed++;
   endtask

   task automatic test_full_pop_accept();
      logic [LANES*DW-1:0] row;
      logic [OW-1:0]       e;
      idle_inputs();
      for (int r = 0; r < DEPTH; r++) begin
         for (int k = 0; k < LANES; k++) row[k*DW +: DW] = DW'(8'hC0 + r*16 + k);
         drive_row(row, 8'hFF);
         expect_row(row);
         tick();
      end
      idle_inputs();
      checks++;
      if (bus.level !== 3'd4) $display("FAIL fill: level=%0d, required 4", bus.level);
      else passed++;
      e = exp_q.pop_front();
      checks++;
      if (bus.out_r !== e) $display("FAIL full beat0: out_r=%h, required %h", bus.out_r, e);
      else passed++;
      bus.rread = 1'b1;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.out_r !== e) $display("FAIL full beat1: out_r=%h, required %h", bus.out_r, e);
      else passed++;
      drive_row(64'hDEADBEEF01234567, 8'hFF);
      expect_row(64'hDEADBEEF01234567);
      tick();
      idle_inputs();
      checks++;
      if (bus.level !== 3'd4 || bus.ovf !== 1'b0)
         $display("FAIL pop-accept: level=%0d ovf=%b, required 4 0", bus.level, bus.ovf);
      else passed++;
      drain("pop_accept");
   endtask

   task automatic test_reset_mid();
      logic [OW-1:0] e;
      idle_inputs();
      drive_row(64'h1122334455667788, 8'hFF);
      expect_row(64'h1122334455667788);
      tick();
      idle_inputs();
      e = exp_q.pop_front();
      checks++;
      if (bus.out_r !== e) $display("FAIL pre-reset beat0: out_r=%h, required %h", bus.out_r, e);
      else passed++;
      bus.rread = 1'b1;
      tick();
      bus.rread = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_v = LANES'(1) << k;
         bus.in_r[k] = 8'h50;
         tick();
      end
      idle_inputs();
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.rvalid !== 1'b0 || bus.level !== 3'd0 || bus.out_r !== 32'h0)
         $display("FAIL async reset: rvalid=%b level=%0d out_r=%h, required 0 0 0",
                  bus.rvalid, bus.level, bus.out_r);
      else passed++;
      exp_q.delete();
      tick();
      rstn = 1'b1;
      tick();
      checks++;
      if (bus.rvalid !== 1'b0 || bus.level !== 3'd0)
         $display("FAIL residual after reset: rvalid=%b level=%0d, required 0 0", bus.rvalid, bus.level);
      else passed++;
      drive_row(64'h8877665544332211, 8'hFF);
      expect_row(64'h8877665544332211);
      tick();
      idle_inputs();
      drain("post_reset");
   endtask

   initial begin
      test_reset();
      test_full_row();
      test_skewed();
      test_collision();
      test_overflow();
      test_full_pop_accept();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/col_output_packer.md
COL_OUTPUT_PACKER -- requirements
Module: col_output_packer

Interface
REQ-001 SHALL have parameter LANES, default 8: number of systolic column lanes.
REQ-002 SHALL have parameter DW, default 8: bits per lane.
REQ-003 SHALL have parameter OW, default 32: output word width; LANES*DW SHALL be an integer multiple of OW, and OW a multiple of DW (elaboration error otherwise).
REQ-004 SHALL have parameter DEPTH, default 4: row FIFO depth in rows, power of 2, >=2.
REQ-005 SHALL provide ports:
 clk  in  1  clock, all state on rising edge
 rstn  in  1  reset, asynchronous, active-low
 in_r  in  LANES x DW  per-lane result data (unpacked array)
 in_v  in  LANES  per-lane valid
 rread  in  1  consumer read strobe
 clr_err  in  1  synchronous clear of sticky flags
 out_r  out  OW  current output word
 rvalid  out  1  out_r holds valid data
 level  out  clog2(DEPTH)+1  rows held in FIFO
 ovf  out  1  sticky: row dropped on full FIFO
 coll  out  1  sticky: lane re-captured before row complete
REQ-006 SHALL use only clk; reset asynchronous and active-low on rstn.

Function
REQ-007 SHALL hold per-lane staging register and captured bit; lane k with in_v[k]=1 SHALL load in_r[k] and set captured[k].
REQ-008 Row complete SHALL be detected combinationally when (captured | in_v) is all ones.
REQ-009 On row complete SHALL push row {lane k = in_v[k] ? in_r[k] : stage[k]} into FIFO the same edge and clear all captured bits, skewed (staggered) lane arrival supported.
REQ-010 in_v[k]=1 while captured[k]=1 and row not completing SHALL overwrite stage[k] and set coll.
REQ-011 Row complete with FIFO full and no same-cycle final-beat pop SHALL drop row, clear captured bits, set ovf, leave FIFO unchanged.
REQ-012 Row complete with FIFO full and same-cycle final-beat pop SHALL accept row (level unchanged).
REQ-013 Each row SHALL be emitted as BEATS = LANES*DW/OW words; beat b SHALL carry lanes b*(OW/DW) .. (b+1)*(OW/DW)-1, lowest lane in lowest bits.
REQ-014 rvalid SHALL equal (level != 0); out_r SHALL be head row, current beat, combinationally from registered state.
REQ-015 rread=1 with rvalid=1 SHALL advance beat counter; on beat BEATS-1 SHALL pop head row and reset beat counter to 0.
REQ-016 rread with rvalid=0 SHALL be ignored, no state change.
REQ-017 Push-to-rvalid latency SHALL be 1 cycle (rvalid high the cycle after completing edge).
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; level SHALL reach exactly DEPTH when full.
REQ-019 clr_err=1 SHALL clear ovf and coll next edge; a new set event same cycle SHALL win (flag stays 1).
REQ-020 out_r SHALL be 0 when rvalid=0.

Reset
REQ-021 rstn low SHALL immediately clear captured bits, stage registers, FIFO pointers, beat counter, level, ovf, coll; out_r=0, rvalid=0.
REQ-022 Reset mid-row or mid-readout SHALL discard all partial and stored rows; no residual beats after release.
REQ-023 First capture SHALL be possible on first rising edge with rstn high.

Verification (defaults)
REQ-024 All in_v=1, in_r[k]=k+1, one cycle -> next cycle rvalid=1, out_r=0x04030201; rread -> 0x08070605; rread -> rvalid=0, level=0.
REQ-025 Skewed arrival: in_v[k] alone in cycle k, k=0..7 -> no push before cycle 7; row pushed at cycle 7 edge, same words as REQ-024, coll=0.
REQ-026 Lane 2 valid twice (0x11 then 0x22) before completion -> coll=1, emitted lane 2 byte = 0x22; clr_err -> coll=0.
REQ-027 Push 5 full rows with no reads -> level=4, ovf=1, first 4 rows read back intact in order, 5th absent.
REQ-028 FIFO full, row completes same cycle as final-beat rread -> row accepted, level stays 4, ovf=0.
REQ-029 rstn pulsed low after first beat read, mid-skewed-row -> rvalid=0, level=0 immediately; new full row after release reads back correctly from beat 0.
